// File: rtl/core_ctrl.sv
// Pass sequencer for computing_core: weight load, credit-throttled window issue, psum drain.
// Optional watchdog on WLOAD/DRAIN enabled by defining CORE_CTRL_WATCHDOG_EN.
module core_ctrl #(
  parameter int WIDTH       = 8,
  parameter int CNT_W       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int WDOG_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_win,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             weight_load,
  input  logic             weight_load_done,
  input  logic             act_valid,
  output logic             activate_ready,
  input  logic             out_psum_vld,
  input  logic             psum_pop
);

  if (WIDTH < 1 || CNT_W < 1 || FIFO_DEPTH < 1 || FIFO_DEPTH > (1 << CNT_W) - 1 ||
      WDOG_CYCLES < 2) begin : g_param_check
    $error("core_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] num_win_q;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] recv_cnt;
  logic [CNT_W-1:0] credits;
  logic             err_q;

  logic             start_ok;
  logic             issue;
  logic             psum_ok;
  logic             psum_bad;
  logic             pop_bad;
  logic             last_issue;
  logic             last_recv;
  logic             wdog_hit;
  logic             wdog_trip;

  // Event decode; everything here is a function of registered state plus the live inputs.
  always_comb begin
    start_ok   = (state_q == S_IDLE) && start;
    issue      = (state_q == S_STREAM) && act_valid && (credits != '0) &&
                 (issue_cnt != num_win_q);
    psum_ok    = out_psum_vld && ((state_q == S_STREAM) || (state_q == S_DRAIN)) &&
                 (recv_cnt != issue_cnt);
    psum_bad   = out_psum_vld && !psum_ok;
    // A pop paired with an issue is a credit swap, never an overflow.
    pop_bad    = psum_pop && !issue && (credits == CREDIT_MAX);
    last_issue = issue && ((issue_cnt + ONE) == num_win_q);
    // Looking one psum ahead lets done follow the final psum by a single cycle.
    last_recv  = (recv_cnt == num_win_q) || (psum_ok && ((recv_cnt + ONE) == num_win_q));
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d   = state_q;
    wdog_trip = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = (num_win == '0) ? S_DONE : S_WLOAD;
      end
      S_WLOAD: begin
        if (weight_load_done) begin
          state_d = S_STREAM;
        end else if (wdog_hit) begin
          state_d   = S_DONE;
          wdog_trip = 1'b1;
        end
      end
      S_STREAM: begin
        if (last_issue) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_recv) begin
          state_d = S_DONE;
        end else if (wdog_hit) begin
          state_d   = S_DONE;
          wdog_trip = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      num_win_q <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      credits   <= CREDIT_MAX;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;

      if (start_ok) begin
        err_q <= 1'b0;
      end else if (psum_bad || pop_bad || wdog_trip) begin
        err_q <= 1'b1;
      end

      if (start_ok && (num_win != '0)) begin
        num_win_q <= num_win;
        issue_cnt <= '0;
        recv_cnt  <= '0;
        credits   <= CREDIT_MAX;
      end else begin
        if (issue)   issue_cnt <= issue_cnt + ONE;
        if (psum_ok) recv_cnt  <= recv_cnt + ONE;
        // Credits move only when exactly one of issue/pop happens; overflow pops are dropped.
        if (issue && !psum_pop) begin
          credits <= credits - ONE;
        end else if (!issue && psum_pop && (credits != CREDIT_MAX)) begin
          credits <= credits + ONE;
        end
      end
    end
  end

`ifdef CORE_CTRL_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_run;

  assign wdog_run = (state_q == S_WLOAD) || (state_q == S_DRAIN);
  assign wdog_hit = wdog_run && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

  // Any sign of progress, or leaving the waiting state, restarts the count.
  always_ff @(posedge clk) begin
    if (rst || !wdog_run || (state_d != state_q) || weight_load_done || out_psum_vld) begin
      wdog_cnt <= '0;
    end else begin
      wdog_cnt <= wdog_cnt + WDOG_W'(1);
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign weight_load    = (state_q == S_WLOAD);
  assign activate_ready = issue;
  assign err            = err_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: scoreboard of expected passes checked at each done pulse,
// plus per-scenario cycle-accurate checks. Watchdog scenario runs only with CORE_CTRL_WATCHDOG_EN.
`timescale 1ns/1ps
module tb_core_ctrl;
  localparam int CNT_W      = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int WDOG       = 16;

  typedef struct {
    int   wins;
    logic err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_win = '0;
  logic             busy, done, err, weight_load, activate_ready;
  logic             weight_load_done = 1'b0;
  logic             act_valid = 1'b0;
  logic             out_psum_vld = 1'b0;
  logic             psum_pop = 1'b0;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   core_en = 1'b0;
  logic [2:0] pipe = '0;
  logic pv_prev = 1'b0;
  int   issues = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   last_psum_cyc = -1;
  int   start_cyc = -1;
  bit   wl_seen = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  core_ctrl #(
    .WIDTH      (8),
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .num_win         (num_win),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .weight_load     (weight_load),
    .weight_load_done(weight_load_done),
    .act_valid       (act_valid),
    .activate_ready  (activate_ready),
    .out_psum_vld    (out_psum_vld),
    .psum_pop        (psum_pop)
  );

  // One clock cycle: apply inputs 1ns after the edge, observe outputs 1ns later.
  // The core model returns a psum 3 cycles after each issue and the downstream FIFO pops it next cycle.
  task automatic step(input logic st = 1'b0, input logic av = 1'b0, input logic pop = 1'b0,
                      input logic wld = 1'b0, input logic pv = 1'b0, input logic rs = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    rst              = rs;
    start            = st;
    act_valid        = av;
    weight_load_done = wld;
    out_psum_vld     = pv | (core_en & pipe[2]);
    psum_pop         = pop | (core_en & pv_prev);
    #1;
    if (activate_ready === 1'b1) issues++;
    if (weight_load === 1'b1) wl_seen = 1'b1;
    if (out_psum_vld) last_psum_cyc = cyc;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_done: done at cycle %0d with no pass outstanding", cyc);
      end else begin
        e = exp_q.pop_front();
        if (issues !== e.wins || err !== e.err) begin
          miscompares++;
          $display("FAIL sb_pass: got windows=%0d err=%b, expected windows=%0d err=%b",
                   issues, err, e.wins, e.err);
        end
      end
    end
    pipe    = {pipe[1:0], activate_ready & core_en};
    pv_prev = out_psum_vld & core_en;
  endtask

  task automatic launch(input int n, input int exp_wins, input logic exp_err);
    exp_t e;
    num_win = CNT_W'(n);
    e.wins  = exp_wins;
    e.err   = exp_err;
    exp_q.push_back(e);
    step(.st(1'b1));
    issues    = 0;
    wl_seen   = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget, input logic av, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(.av(av));
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s_timeout: no done within %0d cycles", tag, budget);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(.rs(1'b1));
      vectors++;
      if ({busy, done, err, weight_load, activate_ready} !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_outputs: got %b, expected 00000",
                 {busy, done, err, weight_load, activate_ready});
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(.av(1'b1));
      vectors++;
      if ({busy, done, err, weight_load, activate_ready} !== 5'b0) begin
        miscompares++;
        $display("FAIL idle_outputs: got %b, expected 00000",
                 {busy, done, err, weight_load, activate_ready});
      end
    end
  endtask

  task automatic test_basic_pass();
    bit ok;
    core_en = 1'b1;
    launch(10, 10, 1'b0);
    step();
    vectors++;
    if (busy !== 1'b1 || weight_load !== 1'b1) begin
      miscompares++;
      $display("FAIL start_latency: busy=%b weight_load=%b, expected 1 1", busy, weight_load);
    end
    step(.wld(1'b1));
    vectors++;
    if (weight_load !== 1'b1 || activate_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL wload_hold: weight_load=%b activate_ready=%b, expected 1 0",
               weight_load, activate_ready);
    end
    step(.av(1'b1));
    vectors++;
    if (weight_load !== 1'b0 || activate_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL wload_exit: weight_load=%b activate_ready=%b, expected 0 1",
               weight_load, activate_ready);
    end
    for (int i = 0; i < 3; i++) step(.av(1'b1));
    vectors++;
    if (issues !== 4) begin
      miscompares++;
      $display("FAIL burst_rate: %0d issues in 4 cycles, expected 4", issues);
    end
    wait_done("basic", 100, 1'b1, ok);
    if (ok) begin
      vectors++;
      if (done_cyc !== last_psum_cyc + 1) begin
        miscompares++;
        $display("FAIL done_latency: done at cycle %0d, expected %0d", done_cyc, last_psum_cyc + 1);
      end
      step();
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_end: busy=%b done=%b err=%b, expected 0 0 0", busy, done, err);
      end
    end
  endtask

  task automatic test_credit_stall();
    core_en = 1'b0;
    launch(10, 10, 1'b0);
    step();
    step(.wld(1'b1));
    for (int i = 0; i < 20; i++) step(.av(1'b1));
    vectors++;
    if (issues !== FIFO_DEPTH || activate_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL credit_stall: issues=%0d activate_ready=%b, expected %0d 0",
               issues, activate_ready, FIFO_DEPTH);
    end
    step(.pop(1'b1));
    step(.pop(1'b1));
    vectors++;
    if (issues !== FIFO_DEPTH) begin
      miscompares++;
      $display("FAIL no_valid_no_issue: issues=%0d, expected %0d", issues, FIFO_DEPTH);
    end
    for (int i = 0; i < 10; i++) step(.av(1'b1));
    vectors++;
    if (issues !== FIFO_DEPTH + 2 || activate_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL credit_return: issues=%0d activate_ready=%b, expected %0d 0",
               issues, activate_ready, FIFO_DEPTH + 2);
    end
    step(.rs(1'b1));
    exp_q.delete();
    step();
    vectors++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_abort: busy=%b err=%b, expected 0 0", busy, err);
    end
  endtask

  task automatic test_zero_and_busy_start();
    bit ok;
    core_en = 1'b0;
    launch(0, 0, 1'b0);
    step();
    vectors++;
    if (done !== 1'b1 || busy !== 1'b1 || weight_load !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_done: done=%b busy=%b weight_load=%b, expected 1 1 0",
               done, busy, weight_load);
    end
    step();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || wl_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_idle: done=%b busy=%b weight_load_seen=%b, expected 0 0 0",
               done, busy, wl_seen);
    end
    core_en = 1'b1;
    launch(6, 6, 1'b0);
    step();
    step(.wld(1'b1));
    step(.av(1'b1));
    step(.av(1'b1));
    num_win = 8'd3;
    step(.st(1'b1), .av(1'b1));
    wait_done("busy_start", 100, 1'b1, ok);
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL start_dropped: busy=%b done=%b after pass, expected 0 0", busy, done);
      end
    end
  endtask

  task automatic test_faults();
    bit ok;
    core_en = 1'b0;
    step(.pv(1'b1));
    step();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL stray_psum_err: err=%b, expected 1", err);
    end
    for (int i = 0; i < 3; i++) step();
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL err_sticky: err=%b busy=%b, expected 1 0", err, busy);
    end
    core_en = 1'b1;
    launch(2, 2, 1'b0);
    step();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear_on_start: err=%b, expected 0", err);
    end
    step(.wld(1'b1));
    wait_done("fault_pass", 60, 1'b1, ok);
    step();
    core_en = 1'b0;
    step(.pop(1'b1));
    step();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL pop_full_err: err=%b, expected 1", err);
    end
    launch(3, 0, 1'b0);
    step();
    step(.wld(1'b1));
    step(.pv(1'b1));
    step();
    vectors++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL early_psum_err: err=%b busy=%b, expected 1 1", err, busy);
    end
    step(.rs(1'b1));
    exp_q.delete();
    step();
    vectors++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_clears_err: err=%b busy=%b, expected 0 0", err, busy);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    core_en = 1'b0;
    launch(3, 3, 1'b0);
    step();
    step(.wld(1'b1));
    for (int i = 0; i < 3; i++) step(.av(1'b1));
    step(.av(1'b1));
    vectors++;
    if (busy !== 1'b1 || activate_ready !== 1'b0 || issues !== 3) begin
      miscompares++;
      $display("FAIL drain_wait: busy=%b activate_ready=%b issues=%0d, expected 1 0 3",
               busy, activate_ready, issues);
    end
    step(.rs(1'b1));
    exp_q.delete();
    step(.av(1'b1));
    vectors++;
    if ({busy, done, err, weight_load, activate_ready} !== 5'b0) begin
      miscompares++;
      $display("FAIL mid_reset_idle: got %b, expected 00000",
               {busy, done, err, weight_load, activate_ready});
    end
    core_en = 1'b1;
    launch(5, 5, 1'b0);
    step();
    step(.wld(1'b1));
    for (int i = 0; i < 4; i++) step(.av(1'b1));
    vectors++;
    if (issues !== 4) begin
      miscompares++;
      $display("FAIL credits_restored: %0d issues in 4 cycles, expected 4", issues);
    end
    wait_done("post_reset_pass", 60, 1'b1, ok);
    step();
  endtask

`ifdef CORE_CTRL_WATCHDOG_EN
  task automatic test_watchdog();
    bit ok;
    core_en = 1'b0;
    launch(2, 0, 1'b1);
    wait_done("watchdog", 40, 1'b0, ok);
    if (ok) begin
      vectors++;
      if (done_cyc !== start_cyc + 1 + WDOG) begin
        miscompares++;
        $display("FAIL wdog_timing: done at cycle %0d, expected %0d", done_cyc, start_cyc + 1 + WDOG);
      end
    end
    step();
    vectors++;
    if (busy !== 1'b0 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL wdog_end: busy=%b err=%b, expected 0 1", busy, err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_pass();
    test_credit_stall();
    test_zero_and_busy_start();
    test_faults();
    test_mid_reset();
`ifdef CORE_CTRL_WATCHDOG_EN
    test_watchdog();
`endif
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: %0d passes never completed, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
